fetch_pc_unit: RTL and testbench

//  F-stage PC owner for the P7 pipelined MIPS microsystem. Consumes the D-stage redirect request (branch/jump/jr/jalr/eret taken, target from NPC) and the
//  CP0 exception request. Drives the instruction-memory fetch handshake and the F/D delay-slot flag.

---
 rtl/fetch_pc_unit.sv | 101 ++++++++++
 tb/tb_fetch_pc_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC owner: sequences pc_o, applies D-stage redirects and CP0
// exceptions, and parks a redirect that arrives while instruction memory is
// busy so the delay slot is fetched before the branch target.
module fetch_pc_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_BASE   = 32'h0000_3000,
    parameter logic [31:0] IM_TOP    = 32'h0000_4FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    input  logic        exc_i,
    input  logic        im_ready_i,
    output logic [31:0] pc_o,
    output logic        fetch_req_o,
    output logic        instr_valid_o,
    output logic        bd_o,
    output logic        adel_o
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic {
        ST_RUN        = 1'b0,
        ST_WAIT_REDIR = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   pend_q, pend_d;

    // Next-state, next-PC and pending-target selection.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        unique case (state_q)
            ST_RUN: begin
                if (exc_i) begin
                    pc_d = EXC_ENTRY;
                end else if (stall_i) begin
                    // D re-presents the redirect once the stall clears.
                    pc_d = pc_q;
                end else if (!im_ready_i) begin
                    if (redirect_i) begin
                        pend_d  = target_i;
                        state_d = ST_WAIT_REDIR;
                    end
                end else if (redirect_i) begin
                    pc_d = target_i;
                end else begin
                    pc_d = pc_q + XLEN'(PC_STEP);
                end
            end
            ST_WAIT_REDIR: begin
                // Delay slot at pc_q still outstanding; redirect_i is ignored.
                if (exc_i) begin
                    pc_d    = EXC_ENTRY;
                    pend_d  = '0;
                    state_d = ST_RUN;
                end else if (stall_i || !im_ready_i) begin
                    pc_d = pc_q;
                end else begin
                    pc_d    = pend_q;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, PC and pending-target registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            pc_q    <= PC_RESET;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    // Handshake, delay-slot and address-error outputs; forced quiet in reset.
    always_comb begin
        pc_o          = pc_q;
        fetch_req_o   = 1'b1;
        instr_valid_o = reset & im_ready_i & ~stall_i & ~exc_i;
        bd_o          = reset & (((state_q == ST_RUN) & redirect_i) |
                                 (state_q == ST_WAIT_REDIR));
        adel_o        = (pc_q[1:0] != 2'b00) | (pc_q < IM_BASE) | (pc_q > IM_TOP);
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: queue-based reference model checked every
// cycle, plus literal expectations for the scenarios of interest.
module tb_fetch_pc_unit;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam logic [31:0] IM_TOP    = 32'h0000_4FFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i, redirect_i, exc_i, im_ready_i;
    logic [31:0] target_i;
    logic [31:0] pc_o;
    logic        fetch_req_o, instr_valid_o, bd_o, adel_o;

    int total = 0;
    int bad   = 0;

    fetch_pc_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .target_i     (target_i),
        .exc_i        (exc_i),
        .im_ready_i   (im_ready_i),
        .pc_o         (pc_o),
        .fetch_req_o  (fetch_req_o),
        .instr_valid_o(instr_valid_o),
        .bd_o         (bd_o),
        .adel_o       (adel_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the PC, plus at most one parked branch target.
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc = PC_RESET;
            m_pend.delete();
        end else if (exc_i) begin
            m_pc = EXC_ENTRY;
            m_pend.delete();
        end else if (m_pend.size() != 0) begin
            if (!stall_i && im_ready_i) m_pc = m_pend.pop_front();
        end else if (!stall_i) begin
            if (!im_ready_i) begin
                if (redirect_i) m_pend.push_back(target_i);
            end else begin
                m_pc = redirect_i ? target_i : m_pc + 32'd4;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic exp_adel;
        exp_adel = (m_pc % 4 != 0) || (m_pc < IM_BASE) || (m_pc > IM_TOP);
        chk("model_pc", pc_o, m_pc);
        chk("model_fetch_req", 32'(fetch_req_o), 32'd1);
        chk("model_instr_valid", 32'(instr_valid_o),
            32'(reset && im_ready_i && !stall_i && !exc_i));
        chk("model_bd", 32'(bd_o), 32'(reset && (m_pend.size() != 0 || redirect_i)));
        chk("model_adel", 32'(adel_o), 32'(exp_adel));
    end

    // One cycle of stimulus, applied just after the rising edge.
    task automatic drive(input logic s, input logic r, input logic [31:0] t,
                         input logic e, input logic y);
        @(posedge clk);
        #1;
        stall_i    = s;
        redirect_i = r;
        target_i   = t;
        exc_i      = e;
        im_ready_i = y;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; target_i = '0;
        exc_i = 1'b0; im_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc_o, 32'h3000);
        chk("rst_fetch_req", 32'(fetch_req_o), 32'd1);
        chk("rst_instr_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_bd", 32'(bd_o), 32'd0);
        chk("rst_adel", 32'(adel_o), 32'd0);

        // T1: sequential fetch after reset release
        reset = 1'b1;
        #2;
        chk("t1_pc0", pc_o, 32'h3000);
        chk("t1_valid0", 32'(instr_valid_o), 32'd1);
        idle();
        chk("t1_pc1", pc_o, 32'h3004);
        chk("t1_valid1", 32'(instr_valid_o), 32'd1);
        idle();
        chk("t1_pc2", pc_o, 32'h3008);
        chk("t1_req2", 32'(fetch_req_o), 32'd1);
        idle();
        chk("t1_pc3", pc_o, 32'h300C);

        // T2: redirect with IM ready
        drive(1'b0, 1'b1, 32'h3100, 1'b0, 1'b1);
        chk("t2_pc", pc_o, 32'h3010);
        chk("t2_bd", 32'(bd_o), 32'd1);
        idle();
        chk("t2_target", pc_o, 32'h3100);
        chk("t2_bd_after", 32'(bd_o), 32'd0);
        idle();
        chk("t2_target4", pc_o, 32'h3104);

        // T3: redirect while IM waits two cycles
        drive(1'b0, 1'b1, 32'h3010, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 32'h3100, 1'b0, 1'b0);
        chk("t3_pc_w0", pc_o, 32'h3010);
        chk("t3_bd_w0", 32'(bd_o), 32'd1);
        chk("t3_valid_w0", 32'(instr_valid_o), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t3_pc_w1", pc_o, 32'h3010);
        chk("t3_bd_w1", 32'(bd_o), 32'd1);
        idle();
        chk("t3_pc_slot", pc_o, 32'h3010);
        chk("t3_valid_slot", 32'(instr_valid_o), 32'd1);
        chk("t3_bd_slot", 32'(bd_o), 32'd1);
        idle();
        chk("t3_target", pc_o, 32'h3100);
        chk("t3_bd_after", 32'(bd_o), 32'd0);

        // T4: stall with redirect held; redirect re-presented after stall
        drive(1'b0, 1'b1, 32'h3020, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h3200, 1'b0, 1'b1);
            chk("t4_pc_hold", pc_o, 32'h3020);
            chk("t4_valid_hold", 32'(instr_valid_o), 32'd0);
        end
        drive(1'b0, 1'b1, 32'h3200, 1'b0, 1'b1);
        chk("t4_pc_release", pc_o, 32'h3020);
        idle();
        chk("t4_target", pc_o, 32'h3200);

        // T5a: exception while a redirect is parked
        drive(1'b0, 1'b1, 32'h3100, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("t5a_bd_wait", 32'(bd_o), 32'd1);
        idle();
        chk("t5a_exc_pc", pc_o, 32'h4180);
        chk("t5a_bd_clear", 32'(bd_o), 32'd0);
        idle();
        chk("t5a_no_pend", pc_o, 32'h4184);
        idle();
        chk("t5a_no_pend2", pc_o, 32'h4188);

        // T5b: exception together with stall
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("t5b_valid", 32'(instr_valid_o), 32'd0);
        idle();
        chk("t5b_exc_pc", pc_o, 32'h4180);

        // T6: bad targets, PC wrap, async reset mid-wait
        drive(1'b0, 1'b1, 32'h3102, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 32'h5000, 1'b0, 1'b1);
        chk("t6_misalign_pc", pc_o, 32'h3102);
        chk("t6_misalign_adel", 32'(adel_o), 32'd1);
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        chk("t6_above_pc", pc_o, 32'h5000);
        chk("t6_above_adel", 32'(adel_o), 32'd1);
        idle();
        chk("t6_top_pc", pc_o, 32'hFFFF_FFFC);
        idle();
        chk("t6_wrap_pc", pc_o, 32'h0000_0000);
        chk("t6_wrap_adel", 32'(adel_o), 32'd1);
        drive(1'b0, 1'b1, 32'h3300, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t6_wait_bd", 32'(bd_o), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_async_pc", pc_o, 32'h3000);
        chk("t6_async_bd", 32'(bd_o), 32'd0);
        chk("t6_async_adel", 32'(adel_o), 32'd0);
        im_ready_i = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        chk("t6_after_rst", pc_o, 32'h3000);
        idle();
        chk("t6_pend_lost", pc_o, 32'h3004);
        idle();
        chk("t6_pend_lost2", pc_o, 32'h3008);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
